// File: rtl/riscv_dm_pkg.sv
// Shared RISC-V debug transport constants and the dtmcs register layout.
// No logic; types and constants only.
// Imported by the DTM data-register controller and its helpers.
package riscv_dm_pkg;

  // DMI request opcodes as shifted into the dmi register
  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  // DMI response / sticky status codes
  localparam logic [1:0] RD_OP_SUCCESS = 2'd0;
  localparam logic [1:0] RD_OP_FAILED  = 2'd2;
  localparam logic [1:0] RD_OP_BUSY    = 2'd3;

  // Debug spec 0.13 transport
  localparam logic [3:0] DTM_VERSION = 4'd1;

  typedef struct packed {
    logic [13:0] rsvd_hi;       // [31:18]
    logic        dtmhardreset;  // [17]
    logic        dmireset;      // [16]
    logic        rsvd_lo;       // [15]
    logic [2:0]  idle;          // [14:12]
    logic [1:0]  dmistat;       // [11:10]
    logic [5:0]  abits;         // [9:4]
    logic [3:0]  version;       // [3:0]
  } dtmcs_t;

endpackage

// File: rtl/riscv_dtm_shift_reg.sv
// JTAG data-register shifter: parallel capture, LSB-first serial shift.
// Capture and shift take effect at the edge where their strobe is sampled.
// Capture has priority over shift; tdo is always the current LSB.
module riscv_dtm_shift_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_en,
  input  logic             shift_en,
  input  logic             tdi,
  input  logic [WIDTH-1:0] cap_data,
  output logic [WIDTH-1:0] q,
  output logic             tdo
);

  // Load the parallel value on capture, otherwise shift toward the LSB
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (capture_en) begin
      q <= cap_data;
    end else if (shift_en) begin
      q <= {tdi, q[WIDTH-1:1]};
    end
  end

  assign tdo = q[0];

endmodule

// File: rtl/riscv_dtm_dmi_ctrl.sv
// DTM dtmcs/dmi data registers plus the DMI request/response handshake.
// Update to req_valid: 1 cycle; update to IDLE: 3 cycles minimum.
// Holds the request until req_ready; aborts a WAIT after TIMEOUT_CYCLES.
module riscv_dtm_dmi_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned IDLE_CYCLES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  tck_i,
  input  logic                  trst_i,
  input  logic                  dtmcs_select_i,
  input  logic                  dmi_select_i,
  input  logic                  capture_dr_i,
  input  logic                  shift_dr_i,
  input  logic                  update_dr_i,
  input  logic                  tdi_i,
  output logic                  dtmcs_tdo_o,
  output logic                  dmi_tdo_o,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  output logic [DATA_WIDTH-1:0] req_data_o,
  output logic [1:0]            req_op_o,
  input  logic                  resp_valid_i,
  output logic                  resp_ready_o,
  input  logic [DATA_WIDTH-1:0] resp_data_i,
  input  logic [1:0]            resp_op_i,
  output logic                  timeout_o
);
  import riscv_dm_pkg::*;

  localparam int unsigned DMI_W   = ADDR_WIDTH + DATA_WIDTH + 2;
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Abort on the cycle whose edge would bring the counter to TIMEOUT_CYCLES
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            op;
  } dmi_t;

  logic [1:0]            state;
  logic [1:0]            dmistat;
  logic [DATA_WIDTH-1:0] data_out;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  drop_pending;
  logic [CNT_W-1:0]      cnt;

  dmi_t   dmi_q;
  dmi_t   dmi_cap;
  dtmcs_t dtmcs_q;
  dtmcs_t dtmcs_cap;

  logic dmi_capture;
  logic dmi_update;
  logic dtmcs_update;
  logic dmi_reset;
  logic hard_reset;
  logic wait_resp;
  logic timeout_hit;
  logic update_ok;
  logic unused_dtmcs;

  assign dmi_capture  = dmi_select_i & capture_dr_i;
  assign dmi_update   = dmi_select_i & update_dr_i;
  assign dtmcs_update = dtmcs_select_i & update_dr_i;
  assign dmi_reset    = dtmcs_update & dtmcs_q.dmireset;
  assign hard_reset   = dtmcs_update & dtmcs_q.dtmhardreset;
  assign wait_resp    = (state == ST_WAIT) & resp_valid_i;
  // A response arriving on the deadline cycle wins over the abort
  assign timeout_hit  = (TIMEOUT_CYCLES != 32'd0) && (state == ST_WAIT) &&
                        !resp_valid_i && (cnt == CNT_W'(TO_LAST));
  assign update_ok    = dmi_update && (state == ST_IDLE) && (dmistat == RD_OP_SUCCESS) &&
                        ((dmi_q.op == DMI_OP_READ) || (dmi_q.op == DMI_OP_WRITE));

  assign req_valid_o  = (state == ST_REQ);
  assign resp_ready_o = (state != ST_REQ);
  assign timeout_o    = timeout_hit & ~hard_reset;

  // Only the reset-request bits of dtmcs are writable
  assign unused_dtmcs = ^{dtmcs_q.rsvd_hi, dtmcs_q.rsvd_lo, dtmcs_q.idle,
                          dtmcs_q.dmistat, dtmcs_q.abits, dtmcs_q.version};

  // dtmcs capture value: static capabilities plus live sticky status
  always_comb begin
    dtmcs_cap         = '0;
    dtmcs_cap.version = DTM_VERSION;
    dtmcs_cap.abits   = 6'(ADDR_WIDTH);
    dtmcs_cap.dmistat = dmistat;
    dtmcs_cap.idle    = 3'(IDLE_CYCLES);
  end

  // dmi capture value: results when idle, otherwise report busy in place
  always_comb begin
    dmi_cap = dmi_q;
    if (state == ST_IDLE) begin
      dmi_cap.addr = last_addr;
      dmi_cap.data = data_out;
      dmi_cap.op   = dmistat;
    end else begin
      dmi_cap.op   = RD_OP_BUSY;
    end
  end

  riscv_dtm_shift_reg #(.WIDTH(32)) u_dtmcs_sr (
    .clk        (tck_i),
    .rst        (trst_i),
    .capture_en (dtmcs_select_i & capture_dr_i),
    .shift_en   (dtmcs_select_i & shift_dr_i),
    .tdi        (tdi_i),
    .cap_data   (dtmcs_cap),
    .q          (dtmcs_q),
    .tdo        (dtmcs_tdo_o)
  );

  riscv_dtm_shift_reg #(.WIDTH(DMI_W)) u_dmi_sr (
    .clk        (tck_i),
    .rst        (trst_i),
    .capture_en (dmi_capture),
    .shift_en   (dmi_select_i & shift_dr_i),
    .tdi        (tdi_i),
    .cap_data   (dmi_cap),
    .q          (dmi_q),
    .tdo        (dmi_tdo_o)
  );

  // Sticky status: busy on collisions, resets override everything
  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      dmistat <= RD_OP_SUCCESS;
    end else if (dmi_reset || hard_reset) begin
      dmistat <= RD_OP_SUCCESS;
    end else if ((dmi_capture || dmi_update) && (state != ST_IDLE)) begin
      dmistat <= RD_OP_BUSY;
    end else if (dmistat == RD_OP_SUCCESS) begin
      if (wait_resp) begin
        dmistat <= (resp_op_i == 2'd1) ? RD_OP_FAILED : resp_op_i;
      end else if (timeout_hit) begin
        dmistat <= RD_OP_FAILED;
      end
    end
  end

  // Handshake FSM, request latches, result data and late-response drain
  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      state        <= ST_IDLE;
      req_addr_o   <= '0;
      req_data_o   <= '0;
      req_op_o     <= DMI_OP_NOP;
      last_addr    <= '0;
      data_out     <= '0;
      drop_pending <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (update_ok) begin
            state      <= ST_REQ;
            req_addr_o <= dmi_q.addr;
            req_data_o <= dmi_q.data;
            req_op_o   <= dmi_q.op;
            last_addr  <= dmi_q.addr;
          end
          if (drop_pending && resp_valid_i) begin
            drop_pending <= 1'b0;
          end
        end
        ST_REQ: begin
          if (req_ready_i) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (cnt != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt <= cnt + 1'b1;
          end
          if (resp_valid_i) begin
            state    <= ST_IDLE;
            data_out <= resp_data_i;
          end else if (timeout_hit) begin
            state        <= ST_IDLE;
            drop_pending <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A response already in flight (or consumed this cycle) must not leak
      // into the next transaction's result
      if (hard_reset) begin
        state    <= ST_IDLE;
        data_out <= '0;
        if (((state == ST_WAIT) && !resp_valid_i) || ((state == ST_REQ) && req_ready_i)) begin
          drop_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_dtm_dmi_ctrl.sv
// Directed bench for riscv_dtm_dmi_ctrl (ADDR_WIDTH 12, IDLE 5, TIMEOUT 8).
// Drives TAP scans and a hand-stepped debug-module port.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_riscv_dtm_dmi_ctrl;

  logic        tck_i = 1'b0;
  logic        trst_i = 1'b1;
  logic        dtmcs_select_i = 1'b0;
  logic        dmi_select_i = 1'b0;
  logic        capture_dr_i = 1'b0;
  logic        shift_dr_i = 1'b0;
  logic        update_dr_i = 1'b0;
  logic        tdi_i = 1'b0;
  logic        dtmcs_tdo_o;
  logic        dmi_tdo_o;
  logic        req_valid_o;
  logic        req_ready_i = 1'b0;
  logic [11:0] req_addr_o;
  logic [31:0] req_data_o;
  logic [1:0]  req_op_o;
  logic        resp_valid_i = 1'b0;
  logic        resp_ready_o;
  logic [31:0] resp_data_i = 32'd0;
  logic [1:0]  resp_op_i = 2'd0;
  logic        timeout_o;

  int checks = 0;
  int failures = 0;
  logic [63:0] dout;

  riscv_dtm_dmi_ctrl #(
    .ADDR_WIDTH     (12),
    .DATA_WIDTH     (32),
    .IDLE_CYCLES    (5),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .tck_i          (tck_i),
    .trst_i         (trst_i),
    .dtmcs_select_i (dtmcs_select_i),
    .dmi_select_i   (dmi_select_i),
    .capture_dr_i   (capture_dr_i),
    .shift_dr_i     (shift_dr_i),
    .update_dr_i    (update_dr_i),
    .tdi_i          (tdi_i),
    .dtmcs_tdo_o    (dtmcs_tdo_o),
    .dmi_tdo_o      (dmi_tdo_o),
    .req_valid_o    (req_valid_o),
    .req_ready_i    (req_ready_i),
    .req_addr_o     (req_addr_o),
    .req_data_o     (req_data_o),
    .req_op_o       (req_op_o),
    .resp_valid_i   (resp_valid_i),
    .resp_ready_o   (resp_ready_o),
    .resp_data_i    (resp_data_i),
    .resp_op_i      (resp_op_i),
    .timeout_o      (timeout_o)
  );

  always #5 tck_i = ~tck_i;

  task automatic step();
    @(posedge tck_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_dmi(input logic [11:0] a, input logic [31:0] d, input logic [1:0] op);
    return {18'd0, a, d, op};
  endfunction

  // Full DR scan: capture, shift n bits LSB first, update
  task automatic scan(input bit is_dmi, input int n, input logic [63:0] din, output logic [63:0] dout_v);
    dout_v = '0;
    dmi_select_i   = is_dmi;
    dtmcs_select_i = !is_dmi;
    capture_dr_i = 1'b1;
    step();
    capture_dr_i = 1'b0;
    shift_dr_i   = 1'b1;
    for (int i = 0; i < n; i++) begin
      tdi_i     = din[i];
      dout_v[i] = is_dmi ? dmi_tdo_o : dtmcs_tdo_o;
      step();
    end
    shift_dr_i  = 1'b0;
    tdi_i       = 1'b0;
    update_dr_i = 1'b1;
    step();
    update_dr_i    = 1'b0;
    dmi_select_i   = 1'b0;
    dtmcs_select_i = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    step();
    step();
    check("rst_req_valid", 64'(req_valid_o), 64'd0);
    check("rst_resp_ready", 64'(resp_ready_o), 64'd1);
    check("rst_req_fields", {req_op_o, req_data_o, 18'd0, req_addr_o}, 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    check("rst_tdos", {62'd0, dmi_tdo_o, dtmcs_tdo_o}, 64'd0);
    trst_i = 1'b0;
    step();

    // ---------------- dtmcs capture ----------------
    scan(1'b0, 32, 64'd0, dout);
    check("dtmcs_capture", dout, 64'h0000_50C1);

    // ---------------- write 0x10 <= 1 ----------------
    scan(1'b1, 46, mk_dmi(12'h010, 32'h1, 2'd2), dout);
    check("wr_req_valid", 64'(req_valid_o), 64'd1);
    check("wr_resp_ready_in_req", 64'(resp_ready_o), 64'd0);
    check("wr_req_addr", 64'(req_addr_o), 64'h10);
    check("wr_req_data", 64'(req_data_o), 64'h1);
    check("wr_req_op", 64'(req_op_o), 64'd2);
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    check("wr_wait_req_valid", 64'(req_valid_o), 64'd0);
    check("wr_wait_resp_ready", 64'(resp_ready_o), 64'd1);
    resp_valid_i = 1'b1; resp_data_i = 32'h0; resp_op_i = 2'd0;
    step();
    resp_valid_i = 1'b0;

    // ---------------- read 0x11 -> 0xABCD ----------------
    scan(1'b1, 46, mk_dmi(12'h011, 32'h0, 2'd1), dout);
    check("rd_req_addr", 64'(req_addr_o), 64'h11);
    check("rd_req_op", 64'(req_op_o), 64'd1);
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    resp_valid_i = 1'b1; resp_data_i = 32'h0000_ABCD; resp_op_i = 2'd0;
    step();
    resp_valid_i = 1'b0;
    scan(1'b1, 46, mk_dmi(12'h011, 32'h0, 2'd0), dout);
    check("rd_result", dout, mk_dmi(12'h011, 32'h0000_ABCD, 2'd0));

    // ---------------- busy ----------------
    scan(1'b1, 46, mk_dmi(12'h012, 32'h0, 2'd1), dout);
    check("busy_first_req", 64'(req_valid_o), 64'd1);
    scan(1'b1, 46, mk_dmi(12'h013, 32'h0, 2'd2), dout);
    check("busy_capture_in_req", dout, mk_dmi(12'h012, 32'h0, 2'd3));
    check("busy_req_addr_held", 64'(req_addr_o), 64'h12);
    check("busy_req_op_held", 64'(req_op_o), 64'd1);
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    resp_valid_i = 1'b1; resp_data_i = 32'h0000_5555; resp_op_i = 2'd0;
    step();
    resp_valid_i = 1'b0;
    scan(1'b1, 46, mk_dmi(12'h012, 32'h0, 2'd0), dout);
    check("busy_sticky_capture", dout, mk_dmi(12'h012, 32'h0000_5555, 2'd3));
    scan(1'b0, 32, 64'd0, dout);
    check("busy_dtmcs_dmistat", dout, 64'h0000_5CC1);
    scan(1'b1, 46, mk_dmi(12'h014, 32'h7, 2'd2), dout);
    check("busy_update_ignored", 64'(req_valid_o), 64'd0);
    scan(1'b0, 32, 64'h0001_0000, dout);
    scan(1'b0, 32, 64'd0, dout);
    check("dmireset_clears", dout, 64'h0000_50C1);

    // ---------------- timeout ----------------
    scan(1'b1, 46, mk_dmi(12'h020, 32'h0, 2'd1), dout);
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    for (int i = 1; i < 8; i++) begin
      check($sformatf("to_quiet_c%0d", i), 64'(timeout_o), 64'd0);
      step();
    end
    check("to_pulse_c8", 64'(timeout_o), 64'd1);
    step();
    check("to_pulse_end", 64'(timeout_o), 64'd0);
    step(); step(); step(); step();
    resp_valid_i = 1'b1; resp_data_i = 32'h0000_DEAD; resp_op_i = 2'd0;
    #1;
    check("to_late_resp_ready", 64'(resp_ready_o), 64'd1);
    step();
    resp_valid_i = 1'b0;
    scan(1'b1, 46, mk_dmi(12'h020, 32'h0, 2'd0), dout);
    check("to_late_dropped", dout, mk_dmi(12'h020, 32'h0000_5555, 2'd2));
    scan(1'b0, 32, 64'h0001_0000, dout);
    check("to_dtmcs_failed", dout, 64'h0000_58C1);

    // ---------------- hard reset during REQ ----------------
    scan(1'b1, 46, mk_dmi(12'h030, 32'h99, 2'd2), dout);
    check("hr_req_before", 64'(req_valid_o), 64'd1);
    scan(1'b0, 32, 64'h0002_0000, dout);
    check("hr_dtmcs_clean", dout, 64'h0000_50C1);
    check("hr_req_dropped", 64'(req_valid_o), 64'd0);
    check("hr_resp_ready", 64'(resp_ready_o), 64'd1);
    scan(1'b1, 46, mk_dmi(12'h030, 32'h0, 2'd0), dout);
    check("hr_dmi_capture", dout, mk_dmi(12'h030, 32'h0, 2'd0));
    scan(1'b1, 46, mk_dmi(12'h031, 32'h0, 2'd1), dout);
    check("hr_idle_accepts", 64'(req_valid_o), 64'd1);
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    resp_valid_i = 1'b1; resp_data_i = 32'h0000_0042; resp_op_i = 2'd0;
    step();
    resp_valid_i = 1'b0;

    // ---------------- synchronous reset during WAIT ----------------
    scan(1'b1, 46, mk_dmi(12'h040, 32'h0, 2'd1), dout);
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    check("sr_in_wait", {62'd0, req_valid_o, resp_ready_o}, 64'd1);
    trst_i = 1'b1;
    step();
    check("sr_req_valid", 64'(req_valid_o), 64'd0);
    check("sr_resp_ready", 64'(resp_ready_o), 64'd1);
    check("sr_req_fields", {req_op_o, req_data_o, 18'd0, req_addr_o}, 64'd0);
    check("sr_timeout", 64'(timeout_o), 64'd0);
    check("sr_tdos", {62'd0, dmi_tdo_o, dtmcs_tdo_o}, 64'd0);
    trst_i = 1'b0;
    step();
    scan(1'b1, 46, 64'd0, dout);
    check("sr_capture_clean", dout, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_dtm_dmi_ctrl.md
# riscv_dtm_dmi_ctrl

Parametrised DTM data-register controller for the RISC-V debug transport. It holds the `dtmcs` and `dmi` JTAG data registers and runs the DMI request/response handshake toward the debug module. It adds the following:

- configurable address width;
- a configurable response timeout;
- sticky busy/failed status with `dmireset` and `dtmhardreset`;
- safe draining of late responses after an abort.

It sits between an external TAP controller, which supplies the DR-state strobes, and the DMI port of the debug module.

## Interface
Parameters:
- `ADDR_WIDTH`, 7: DMI address bits; reported in `dtmcs.abits`. Legal range 7–32.
- `DATA_WIDTH`, 32: DMI data bits.
- `IDLE_CYCLES`, 1: value reported in `dtmcs.idle`. Range 0–7.
- `TIMEOUT_CYCLES`, 1023: cycles allowed in WAIT before abort. 0 disables the timeout.

Ports:
- `tck_i`  in  1  single clock; all logic is clocked on the rising edge.
- `trst_i`  in  1  reset; synchronous, active-high.
- `dtmcs_select_i`, `dmi_select_i`  in  1  active instruction from the TAP.
- `capture_dr_i`, `shift_dr_i`, `update_dr_i`  in  1  TAP DR-state strobes, each one cycle wide.
- `tdi_i`  in  1  serial data in.
- `dtmcs_tdo_o`, `dmi_tdo_o`  out  1  LSB of each shift register.
- `req_valid_o`  out  1  DMI request valid.
- `req_ready_i`  in  1  DMI request accepted.
- `req_addr_o`  out  `ADDR_WIDTH`  request address.
- `req_data_o`  out  `DATA_WIDTH`  request data.
- `req_op_o`  out  2  request op: 1 = read, 2 = write.
- `resp_valid_i`  in  1  DMI response valid.
- `resp_ready_o`  out  1  DMI response accepted.
- `resp_data_i`  in  `DATA_WIDTH`  response data.
- `resp_op_i`  in  2  response status: 0 = ok, 2 = failed, 3 = busy.
- `timeout_o`  out  1  one-cycle pulse when an abort occurs.

## Operation
**DMI register** (`W = ADDR_WIDTH + DATA_WIDTH + 2`; layout `{addr, data, op}`, op at the LSBs):
- Shift, when selected: `reg <= {tdi_i, reg[W-1:1]}`.
- Capture in IDLE: load `{last_addr, data_out, dmistat}`.
- Capture in any other state: the op field becomes 3 and `dmistat` becomes 3 (sticky busy). The address and data fields are left unchanged.
- Update, when `dmistat == 0`, state is IDLE and op ∈ {1, 2}: latch addr/data/op into the request outputs and `last_addr`, then go to REQ.
- Update with op 0 or 3: no action.
- Update with `dmistat != 0`: ignored.
- Update while not IDLE: ignored, and `dmistat` becomes 3.

**State machine:**
- IDLE → REQ on a valid update (see above).
- REQ: `req_valid_o = 1` and `resp_ready_o = 0`. Request outputs hold stable. On `req_ready_i` go to WAIT and clear the timeout counter.
- WAIT: `resp_ready_o = 1`. The counter increments every cycle.
  - On `resp_valid_i`: `data_out <= resp_data_i`. If `dmistat == 0`, `dmistat <= resp_op_i` (the value 1 maps to 2). Return to IDLE.
  - If the counter reaches `TIMEOUT_CYCLES` (non-zero) and no response has arrived: `dmistat <= 2` (unless already non-zero), pulse `timeout_o`, set `drop_pending`, and return to IDLE.
- IDLE: `resp_ready_o = 1`.
  - With `drop_pending` set, the next `resp_valid_i` is consumed, `drop_pending` is cleared and the response is discarded.
  - Any other response seen in IDLE is discarded.

**DTMCS register (32 bits):**
- Capture: `version[3:0] = 1`, `abits[9:4] = ADDR_WIDTH`, `dmistat[11:10]`, `idle[14:12] = IDLE_CYCLES`; all other bits 0.
- Update with bit 16 (`dmireset`) set: `dmistat <= 0`.
- Update with bit 17 (`dtmhardreset`) set:
  - `dmistat <= 0`, `data_out <= 0` and the state returns to IDLE.
  - If the state was WAIT, or was REQ with `req_ready_i` high in that cycle, set `drop_pending`.
  - If the state was REQ and the request was not accepted, drop the request.

**Reset values:**
- All registers 0; state IDLE; `drop_pending` 0.
- Outputs: `req_valid_o` 0, `resp_ready_o` 1, request fields 0, `timeout_o` 0, both TDOs 0.

## Timing
- Strobe effects apply at the same edge where the strobe is sampled. `req_valid_o` rises the cycle after `update_dr_i`.
- Minimum transaction latency, from update to IDLE: 3 cycles, assuming `req_ready_i` and `resp_valid_i` each respond in 1 cycle.
- Simultaneous events:
  - Response and capture in the same cycle in WAIT: capture sees the pre-edge state, so it reports busy.
  - Response and `dmireset` in the same cycle: `dmireset` wins on `dmistat`; `data_out` still takes the response.
  - Timeout and response in the same cycle: the response wins.
  - Hard reset and response in the same cycle: hard reset wins; the response is consumed and dropped.
- The timeout counter is `$clog2(TIMEOUT_CYCLES + 1)` bits wide and saturates; it cannot wrap.
- A synchronous reset in the middle of a transaction forces IDLE, even in REQ. The debug module is reset alongside.

## Structure
- `riscv_dm_pkg` holds:
  - the DMI op and status constants (`DMI_OP_NOP`/`READ`/`WRITE`, `RD_OP_SUCCESS`/`FAILED`/`BUSY`);
  - `dtmcs_t`;
  - the DTM version constant.
- The `dmi_t` layout is built locally, because its width depends on the parameters.
- One sub-module, `riscv_dtm_shift_reg`, parametrised by width. It handles parallel capture and serial shift, and is instantiated twice (DTMCS and DMI).

## Test plan
- **Write then read.** Update a DMI write (addr `0x10`, data `0x1`); DM responds `ready = 1` and op 0. Then update a read of `0x11`; DM returns `0xABCD`. Next capture → op 0, data `0xABCD`.
- **Busy.** Update again while in REQ; then capture → op 3, `dtmcs.dmistat = 3`. Further updates are ignored. A `dtmcs` update with bit 16 set clears `dmistat` to 0.
- **Timeout.** Run with `TIMEOUT_CYCLES = 8`; the DM never responds. Required response:
  - `timeout_o` pulses 8 cycles after `req_ready_i`;
  - `dmistat = 2`;
  - a late response arriving 5 cycles later is dropped, leaving `data_out` unchanged.
- **Hard reset.** Issue `dtmhardreset` during REQ with `req_ready_i = 0` → `req_valid_o` falls the next cycle, state IDLE, `dmistat = 0`.
- **DTMCS capture.** With `ADDR_WIDTH = 12` and `IDLE_CYCLES = 5`, a `dtmcs` capture shifts out `0x000050C1`.
- **Reset.** Assert `trst_i` during WAIT → after one edge, all outputs are at their reset values and the next capture → op 0.
